// File: rtl/bus_interconnect.sv
// Serial bus interconnect: NUM_MASTERS masters to NUM_SLAVES slaves; define ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Grant 1 cycle after request, SEL_BITS address bits consumed, then zero-latency routing; losers wait with m_req held.
module bus_interconnect #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_grant,
  input  logic [NUM_MASTERS-1:0] m_master_valid,
  input  logic [NUM_MASTERS-1:0] m_master_ready,
  input  logic [NUM_MASTERS-1:0] m_tx_address,
  input  logic [NUM_MASTERS-1:0] m_tx_data,
  input  logic [NUM_MASTERS-1:0] m_write_en,
  input  logic [NUM_MASTERS-1:0] m_read_en,
  input  logic [NUM_MASTERS-1:0] m_tx_burst_num,
  output logic [NUM_MASTERS-1:0] m_rx_data,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_dec_err,
  output logic [NUM_SLAVES-1:0]  s_master_valid,
  output logic [NUM_SLAVES-1:0]  s_master_ready,
  output logic [NUM_SLAVES-1:0]  s_rx_address,
  output logic [NUM_SLAVES-1:0]  s_rx_data,
  output logic [NUM_SLAVES-1:0]  s_write_en,
  output logic [NUM_SLAVES-1:0]  s_read_en,
  output logic [NUM_SLAVES-1:0]  s_rx_burst_num,
  input  logic [NUM_SLAVES-1:0]  s_tx_data,
  input  logic [NUM_SLAVES-1:0]  s_slave_valid,
  input  logic [NUM_SLAVES-1:0]  s_slave_ready,
  output logic                   busy,
  output logic [SEL_BITS-1:0]    cur_slave
);
  localparam int CW = $clog2(SEL_BITS + 1);
  localparam logic [NUM_MASTERS-1:0] M_ONE = NUM_MASTERS'(1);
  localparam logic [NUM_SLAVES-1:0]  S_ONE = NUM_SLAVES'(1);

  typedef enum logic [2:0] {IDLE, DECODE, CONNECT, ERR, RELEASE} state_t;

  state_t                 state;
  logic [SEL_BITS-1:0]    sel;
  logic [SEL_BITS-1:0]    sel_next;
  logic [CW-1:0]          bit_cnt;
  logic [NUM_MASTERS-1:0] arb_pick;
  logic [NUM_SLAVES-1:0]  slave_mask;
  logic own_req, own_vld, own_rdy, own_addr, own_data, own_we, own_re, own_burst;
  logic ret_data, ret_vld, ret_rdy;

  // m_grant is one-hot while a master owns the bus, so masking picks the owner's bit
  assign own_req   = |(m_req & m_grant);
  assign own_vld   = |(m_master_valid & m_grant);
  assign own_rdy   = |(m_master_ready & m_grant);
  assign own_addr  = |(m_tx_address & m_grant);
  assign own_data  = |(m_tx_data & m_grant);
  assign own_we    = |(m_write_en & m_grant);
  assign own_re    = |(m_read_en & m_grant);
  assign own_burst = |(m_tx_burst_num & m_grant);

  assign sel_next = (sel << 1) | SEL_BITS'(own_addr);

`ifdef ARB_ROUND_ROBIN_EN
  logic [NUM_MASTERS-1:0] last_grant;
  logic [NUM_MASTERS-1:0] above_last;
  logic [NUM_MASTERS-1:0] req_hi;

  // requesters strictly above the last winner get first pick, otherwise wrap to the lowest
  assign above_last = ~((last_grant << 1) - M_ONE);
  assign req_hi     = m_req & above_last;
  assign arb_pick   = (|req_hi) ? (req_hi & (~req_hi + M_ONE)) : (m_req & (~m_req + M_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= M_ONE << (NUM_MASTERS - 1);
    end else if (state == IDLE && |m_req) begin
      last_grant <= arb_pick;
    end
  end
`else
  assign arb_pick = m_req & (~m_req + M_ONE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      m_grant   <= '0;
      sel       <= '0;
      bit_cnt   <= '0;
      cur_slave <= '0;
      m_dec_err <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_req) begin
            m_grant <= arb_pick;
            sel     <= '0;
            bit_cnt <= '0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (!own_req) begin
            m_grant <= '0;
            sel     <= '0;
            bit_cnt <= '0;
            state   <= RELEASE;
          end else if (own_vld) begin
            sel <= sel_next;
            if (bit_cnt == CW'(SEL_BITS - 1)) begin
              bit_cnt <= '0;
              if (int'(sel_next) < NUM_SLAVES) begin
                cur_slave <= sel_next;
                state     <= CONNECT;
              end else begin
                m_dec_err <= m_grant;
                state     <= ERR;
              end
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        CONNECT, ERR: begin
          if (!own_req) begin
            m_grant   <= '0;
            m_dec_err <= '0;
            cur_slave <= '0;
            state     <= RELEASE;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // routing is gated purely by state, so an async reset drops every path at once
  assign slave_mask = (state == CONNECT) ? (S_ONE << cur_slave) : '0;

  assign s_master_valid = {NUM_SLAVES{own_vld}} & slave_mask;
  assign s_master_ready = {NUM_SLAVES{own_rdy}} & slave_mask;
  assign s_rx_address   = {NUM_SLAVES{own_addr}} & slave_mask;
  assign s_rx_data      = {NUM_SLAVES{own_data}} & slave_mask;
  assign s_write_en     = {NUM_SLAVES{own_we}} & slave_mask;
  assign s_read_en      = {NUM_SLAVES{own_re}} & slave_mask;
  assign s_rx_burst_num = {NUM_SLAVES{own_burst}} & slave_mask;

  assign ret_data = |(s_tx_data & slave_mask);
  assign ret_vld  = |(s_slave_valid & slave_mask);
  assign ret_rdy  = |(s_slave_ready & slave_mask);

  assign m_rx_data     = {NUM_MASTERS{ret_data}} & m_grant;
  assign m_slave_valid = {NUM_MASTERS{ret_vld}} & m_grant;
  assign m_slave_ready = {NUM_MASTERS{ret_rdy}} & m_grant;

  assign busy = (state != IDLE);

endmodule
